// File: rtl/segscan_decoder.sv
// Receive-side monitor for the multiplexed 7-segment bus; rebuilds 4-digit frames.
// Optional `lives` output enabled by defining SEGSCAN_LIVES_EN.
module segscan_decoder #(
   parameter int TIMEOUT = 1024
) (
   input  logic        segclk,
   input  logic        clr_n,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  an_in,
   output logic [15:0] digits,
   output logic        frame_valid,
   output logic        seg_err,
   output logic        order_err,
   output logic        stale
`ifdef SEGSCAN_LIVES_EN
   ,
   output logic [1:0]  lives
`endif
);

   typedef enum logic [1:0] {
      WAIT_LEFT,
      GOT_L,
      GOT_ML,
      GOT_MR
   } state_t;

   localparam logic [3:0]  AN_L  = 4'b0111;
   localparam logic [3:0]  AN_ML = 4'b1011;
   localparam logic [3:0]  AN_MR = 4'b1101;
   localparam logic [3:0]  AN_R  = 4'b1110;
   localparam logic [3:0]  CODE_E = 4'hE;
   localparam logic [15:0] TO = 16'(TIMEOUT);

   logic [6:0]  seg_q;
   logic [3:0]  an_q;
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  left_q, left_d;
   logic [3:0]  ml_q, ml_d;
   logic [3:0]  mr_q, mr_d;
   logic [15:0] digits_q, digits_d;
   logic        fv_q, fv_d;
   logic        seg_err_q, seg_err_d;
   logic        oerr_q, oerr_d;
   logic        stale_q, stale_d;

   logic [3:0]  dec;
   logic        an_valid;
   logic        an_multi;
   logic        to_hit;
   logic        cap_l, cap_ml, cap_mr;
   logic        commit;
   logic        oerr_set;

   always_ff @(posedge segclk or negedge clr_n) begin
      if (!clr_n) begin
         seg_q <= 7'h7F;
         an_q  <= 4'hF;
      end else begin
         seg_q <= seg_in;
         an_q  <= an_in;
      end
   end

   always_comb begin
      dec = CODE_E;
      case (seg_q)
         7'b1000000: dec = 4'h0;
         7'b1001111: dec = 4'h1;
         7'b0100100: dec = 4'h2;
         7'b0110000: dec = 4'h3;
         7'b0011001: dec = 4'h4;
         7'b0010010: dec = 4'h5;
         7'b0000010: dec = 4'h6;
         7'b1111000: dec = 4'h7;
         7'b0000000: dec = 4'h8;
         7'b0010000: dec = 4'h9;
         7'b0000110: dec = 4'h3;
         7'b1111111: dec = 4'hF;
         default:    dec = CODE_E;
      endcase
   end

   always_comb begin
      an_valid = (an_q == AN_L) || (an_q == AN_ML) ||
                 (an_q == AN_MR) || (an_q == AN_R);
      an_multi = !an_valid && (an_q != 4'hF);
   end

   // Counter saturates at TIMEOUT; a valid anode always wins over expiry
   always_comb begin
      cnt_d = cnt_q;
      if (an_valid)
         cnt_d = '0;
      else if (cnt_q != TO)
         cnt_d = cnt_q + 16'd1;
      to_hit  = !an_valid && (cnt_d == TO);
      stale_d = stale_q;
      if (an_valid)
         stale_d = 1'b0;
      else if (to_hit)
         stale_d = 1'b1;
   end

   always_ff @(posedge segclk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= WAIT_LEFT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cap_l    = 1'b0;
      cap_ml   = 1'b0;
      cap_mr   = 1'b0;
      commit   = 1'b0;
      oerr_set = 1'b0;
      if (an_multi) begin
         oerr_set = 1'b1;
         state_d  = WAIT_LEFT;
      end else if (an_valid) begin
         unique case (state_q)
            WAIT_LEFT: begin
               if (an_q == AN_L) begin
                  cap_l   = 1'b1;
                  state_d = GOT_L;
               end
            end
            GOT_L: begin
               if (an_q == AN_L) begin
                  cap_l = 1'b1;
               end else if (an_q == AN_ML) begin
                  cap_ml  = 1'b1;
                  state_d = GOT_ML;
               end else begin
                  oerr_set = 1'b1;
                  state_d  = WAIT_LEFT;
               end
            end
            GOT_ML: begin
               if (an_q == AN_ML) begin
                  cap_ml = 1'b1;
               end else if (an_q == AN_MR) begin
                  cap_mr  = 1'b1;
                  state_d = GOT_MR;
               end else begin
                  oerr_set = 1'b1;
                  cap_l    = (an_q == AN_L);
                  state_d  = (an_q == AN_L) ? GOT_L : WAIT_LEFT;
               end
            end
            GOT_MR: begin
               if (an_q == AN_MR) begin
                  cap_mr = 1'b1;
               end else if (an_q == AN_R) begin
                  commit  = 1'b1;
                  state_d = WAIT_LEFT;
               end else begin
                  oerr_set = 1'b1;
                  cap_l    = (an_q == AN_L);
                  state_d  = (an_q == AN_L) ? GOT_L : WAIT_LEFT;
               end
            end
            default: state_d = WAIT_LEFT;
         endcase
      end else if (to_hit) begin
         state_d = WAIT_LEFT;
      end
   end

   always_comb begin
      left_d    = cap_l  ? dec : left_q;
      ml_d      = cap_ml ? dec : ml_q;
      mr_d      = cap_mr ? dec : mr_q;
      digits_d  = digits_q;
      seg_err_d = seg_err_q;
      fv_d      = commit;
      oerr_d    = oerr_q;
      if (commit) begin
         digits_d  = {left_q, ml_q, mr_q, dec};
         seg_err_d = (left_q == CODE_E) || (ml_q == CODE_E) ||
                     (mr_q == CODE_E) || (dec == CODE_E);
         oerr_d    = 1'b0;
      end else if (oerr_set) begin
         oerr_d = 1'b1;
      end
   end

   always_ff @(posedge segclk or negedge clr_n) begin
      if (!clr_n) begin
         cnt_q     <= '0;
         left_q    <= 4'hF;
         ml_q      <= 4'hF;
         mr_q      <= 4'hF;
         digits_q  <= 16'hFFFF;
         fv_q      <= 1'b0;
         seg_err_q <= 1'b0;
         oerr_q    <= 1'b0;
         stale_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         left_q    <= left_d;
         ml_q      <= ml_d;
         mr_q      <= mr_d;
         digits_q  <= digits_d;
         fv_q      <= fv_d;
         seg_err_q <= seg_err_d;
         oerr_q    <= oerr_d;
         stale_q   <= stale_d;
      end
   end

   assign digits      = digits_q;
   assign frame_valid = fv_q;
   assign seg_err     = seg_err_q;
   assign order_err   = oerr_q;
   assign stale       = stale_q;

`ifdef SEGSCAN_LIVES_EN
   logic [1:0] lives_q, lives_d;

   always_comb begin
      lives_d = lives_q;
      if (commit)
         lives_d = (left_q <= 4'd3) ? left_q[1:0] : 2'b00;
   end

   always_ff @(posedge segclk or negedge clr_n) begin
      if (!clr_n) begin
         lives_q <= 2'b00;
      end else begin
         lives_q <= lives_d;
      end
   end

   assign lives = lives_q;
`endif

endmodule

// File: tb/tb_segscan_decoder.sv
// Scoreboard bench for segscan_decoder: expected frames queued at the
// right-digit stimulus and checked on every frame_valid pulse.
module tb_segscan_decoder;

   localparam int TO = 8;

   typedef struct {
      logic [15:0] d;
      logic        e;
      logic [1:0]  l;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic [6:0]  seg_in = 7'h7F;
   logic [3:0]  an_in = 4'hF;
   logic [15:0] digits;
   logic        frame_valid;
   logic        seg_err;
   logic        order_err;
   logic        stale;
   logic [1:0]  lives_o;

   int checks = 0;
   int errs = 0;
   int fv_cnt = 0;
   int cyc = 0;
   int last_fv = 0;
   int prev_fv = 0;
   exp_t sb[$];
   logic [15:0] last_d = 16'hFFFF;

   segscan_decoder #(.TIMEOUT(TO)) dut (
      .segclk(clk),
      .clr_n(clr_n),
      .seg_in(seg_in),
      .an_in(an_in),
      .digits(digits),
      .frame_valid(frame_valid),
      .seg_err(seg_err),
      .order_err(order_err),
      .stale(stale)
`ifdef SEGSCAN_LIVES_EN
      ,
      .lives(lives_o)
`endif
   );

`ifndef SEGSCAN_LIVES_EN
   assign lives_o = 2'b00;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [6:0] pat(input logic [3:0] c);
      case (c)
         4'h0: pat = 7'b1000000;
         4'h1: pat = 7'b1001111;
         4'h2: pat = 7'b0100100;
         4'h3: pat = 7'b0110000;
         4'h4: pat = 7'b0011001;
         4'h5: pat = 7'b0010010;
         4'h6: pat = 7'b0000010;
         4'h7: pat = 7'b1111000;
         4'h8: pat = 7'b0000000;
         4'h9: pat = 7'b0010000;
         default: pat = 7'b1111111;
      endcase
   endfunction

   // Frame checker
   always @(negedge clk) begin
      if (clr_n && frame_valid) begin
         exp_t e;
         fv_cnt++;
         prev_fv = last_fv;
         last_fv = cyc;
         checks++;
         if (sb.size() == 0) begin
            errs++;
            $display("FAIL unexpected_frame: got digits %h, none expected",
                     digits);
         end else begin
            e = sb.pop_front();
            if (digits !== e.d) begin
               errs++;
               $display("FAIL frame_digits: got %h expected %h", digits, e.d);
            end
            checks++;
            if (seg_err !== e.e) begin
               errs++;
               $display("FAIL frame_seg_err: got %b expected %b", seg_err, e.e);
            end
`ifdef SEGSCAN_LIVES_EN
            checks++;
            if (lives_o !== e.l) begin
               errs++;
               $display("FAIL frame_lives: got %0d expected %0d", lives_o, e.l);
            end
`endif
         end
      end
   end

   task automatic scan(input logic [3:0] a, input logic [6:0] s, input int n);
      repeat (n) begin
         @(negedge clk);
         an_in  = a;
         seg_in = s;
      end
   endtask

   task automatic idle(input int n);
      scan(4'hF, 7'h7F, n);
   endtask

   task automatic frame(input logic [6:0] pl, input logic [6:0] pml,
                        input logic [6:0] pmr, input logic [6:0] pr,
                        input logic [15:0] ed, input logic ee, input int hold);
      exp_t e;
      e.d = ed;
      e.e = ee;
      e.l = (ed[15:12] <= 4'd3) ? ed[13:12] : 2'b00;
      scan(4'b0111, pl, hold);
      scan(4'b1011, pml, hold);
      scan(4'b1101, pmr, hold);
      sb.push_back(e);
      last_d = ed;
      scan(4'b1110, pr, hold);
   endtask

   task automatic drain(input string name);
      idle(3);
      checks++;
      if (sb.size() != 0) begin
         errs++;
         $display("FAIL %s: %0d frames still pending, expected 0",
                  name, sb.size());
         sb.delete();
      end
   endtask

   task automatic check_rst(input string name);
      checks++;
      if ({digits, frame_valid, seg_err, order_err, stale, lives_o}
          !== {16'hFFFF, 4'b0000, 2'b00}) begin
         errs++;
         $display("FAIL %s: got d=%h fv=%b se=%b oe=%b st=%b lv=%0d expected reset values",
                  name, digits, frame_valid, seg_err, order_err, stale, lives_o);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1 check_rst("reset_values");
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   task automatic test_basic();
      frame(7'b0000110, 7'h7F, 7'h7F, 7'h7F, 16'h3FFF, 1'b0, 1);
      drain("basic_drain");
      checks++;
      if (order_err !== 1'b0 || stale !== 1'b0) begin
         errs++;
         $display("FAIL basic_flags: got oe=%b st=%b expected 0 0",
                  order_err, stale);
      end
   endtask

   task automatic test_hold();
      int c0;
      c0 = fv_cnt;
      frame(pat(1), pat(0), pat(9), pat(3), 16'h1093, 1'b0, 3);
      drain("hold_drain");
      checks++;
      if (fv_cnt - c0 != 1) begin
         errs++;
         $display("FAIL hold_pulses: got %0d expected 1", fv_cnt - c0);
      end
   endtask

   task automatic test_order();
      int c0;
      c0 = fv_cnt;
      scan(4'b0111, pat(4), 1);
      scan(4'b1101, pat(5), 1);
      idle(3);
      checks++;
      if (order_err !== 1'b1) begin
         errs++;
         $display("FAIL order_set: got %b expected 1", order_err);
      end
      checks++;
      if (fv_cnt != c0) begin
         errs++;
         $display("FAIL order_nocommit: got %0d pulses expected 0", fv_cnt - c0);
      end
      frame(pat(1), pat(2), pat(3), pat(4), 16'h1234, 1'b0, 1);
      drain("order_drain");
      checks++;
      if (order_err !== 1'b0) begin
         errs++;
         $display("FAIL order_clear: got %b expected 0", order_err);
      end
   endtask

   task automatic test_seg_err();
      frame(pat(5), pat(6), pat(7), 7'b1010101, 16'h567E, 1'b1, 1);
      drain("segerr_drain");
      frame(pat(2), pat(9), pat(4), pat(8), 16'h2948, 1'b0, 1);
      drain("segerr_clear_drain");
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = fv_cnt;
      frame(pat(0), pat(1), pat(2), pat(3), 16'h0123, 1'b0, 1);
      frame(pat(8), pat(9), pat(0), pat(2), 16'h8902, 1'b0, 1);
      frame(pat(3), 7'h7F, pat(0), pat(1), 16'h3F01, 1'b0, 1);
      drain("b2b_drain");
      checks++;
      if (fv_cnt - c0 != 3) begin
         errs++;
         $display("FAIL b2b_pulses: got %0d expected 3", fv_cnt - c0);
      end
      checks++;
      if (last_fv - prev_fv != 4) begin
         errs++;
         $display("FAIL b2b_spacing: got %0d cycles expected 4",
                  last_fv - prev_fv);
      end
   endtask

   task automatic test_stale();
      idle(3);
      checks++;
      if (stale !== 1'b0) begin
         errs++;
         $display("FAIL stale_early: got %b expected 0", stale);
      end
      idle(TO + 2);
      checks++;
      if (stale !== 1'b1) begin
         errs++;
         $display("FAIL stale_set: got %b expected 1", stale);
      end
      checks++;
      if (digits !== last_d) begin
         errs++;
         $display("FAIL stale_hold: got %h expected %h", digits, last_d);
      end
      scan(4'b0111, pat(6), 1);
      idle(2);
      @(negedge clk);
      checks++;
      if (stale !== 1'b0) begin
         errs++;
         $display("FAIL stale_clear: got %b expected 0", stale);
      end
      frame(pat(7), pat(6), pat(5), pat(4), 16'h7654, 1'b0, 1);
      drain("stale_drain");
   endtask

   task automatic test_reset_mid();
      int c0;
      scan(4'b0111, pat(9), 1);
      scan(4'b1011, pat(8), 1);
      @(negedge clk);
      @(negedge clk);
      #2 clr_n = 1'b0;
      an_in  = 4'hF;
      seg_in = 7'h7F;
      #1 check_rst("reset_mid_values");
      @(negedge clk);
      clr_n = 1'b1;
      c0 = fv_cnt;
      scan(4'b1101, pat(1), 1);
      scan(4'b1110, pat(2), 1);
      idle(3);
      checks++;
      if (fv_cnt != c0) begin
         errs++;
         $display("FAIL reset_partial: got %0d pulses expected 0", fv_cnt - c0);
      end
      frame(pat(2), pat(0), pat(2), pat(6), 16'h2026, 1'b0, 1);
      drain("reset_mid_drain");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_order();
      test_seg_err();
      test_back_to_back();
      test_stale();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, errs);
      $finish;
   end

endmodule
